// File: rtl/risc_bus_pkg.sv
// Shared types and parameter helpers for the RISC memory-bus controller.
package risc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } bus_state_e;

    // Width of one per-region wait-state field.
    localparam int WAIT_W = 4;

    // Largest region count the wait table helper can index.
    localparam int MAX_NREG = 16;

    // Width of a region index, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pull the wait-state field for region r out of a packed wait table.
    function automatic logic [WAIT_W-1:0] regWait(input logic [MAX_NREG*WAIT_W-1:0] waits,
                                                  input int r);
        return waits[r*WAIT_W +: WAIT_W];
    endfunction

endpackage

// File: rtl/risc_region_match.sv
// Combinational address decoder: finds the lowest-index region whose
// base/mask pair matches the incoming core address.
module risc_region_match
    import risc_bus_pkg::*;
#(
    parameter int AW   = 13,
    parameter int NREG = 2,
    parameter int IW   = 1,
    parameter logic [NREG*AW-1:0] REG_BASE = '0,
    parameter logic [NREG*AW-1:0] REG_MASK = '0
) (
    input  logic [AW-1:0] addr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the highest region down so the lowest matching index is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int r = NREG - 1; r >= 0; r--) begin
            if ((addr_i & REG_MASK[r*AW +: AW]) == REG_BASE[r*AW +: AW]) begin
                hit_o = 1'b1;
                idx_o = IW'(r);
            end
        end
    end

endmodule

// File: rtl/risc_mem_bus_ctrl.sv
// Memory-bus controller between the RISC core and its ROM/RAM/peripheral
// slaves: decodes the address into a region, holds the slave strobes for the
// region's wait states and returns a one-cycle ready/error pulse to the core.
module risc_mem_bus_ctrl
    import risc_bus_pkg::*;
#(
    parameter int AW   = 13,
    parameter int DW   = 8,
    parameter int NREG = 2,
    parameter logic [NREG*AW-1:0]     REG_BASE = {13'h0000, 13'h1800},
    parameter logic [NREG*AW-1:0]     REG_MASK = {13'h0000, 13'h1800},
    parameter logic [NREG*WAIT_W-1:0] REG_WAIT = {4'd1, 4'd0}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_rd_i,
    input  logic               cpu_wr_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [DW-1:0]      cpu_wdata_i,
    output logic [DW-1:0]      cpu_rdata_o,
    output logic               cpu_ready_o,
    output logic               cpu_err_o,
    output logic               busy_o,
    output logic [NREG-1:0]    slv_sel_o,
    output logic               slv_rd_o,
    output logic               slv_wr_o,
    output logic [AW-1:0]      slv_addr_o,
    output logic [DW-1:0]      slv_wdata_o,
    input  logic [NREG*DW-1:0] slv_rdata_i
);

    localparam int IW   = idxWidth(NREG);
    localparam int TABW = MAX_NREG * WAIT_W;
    localparam logic [TABW-1:0] WAIT_TAB = TABW'(REG_WAIT);

    bus_state_e          state_q, state_d;
    logic [AW-1:0]       slvAddr_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       rdata_q;
    logic [IW-1:0]       regIdx_q;
    logic [WAIT_W-1:0]   waitCnt_q;
    logic                isWrite_q;

    logic                matchHit;
    logic [IW-1:0]       matchIdx;
    logic                reqValid;
    logic                reqBad;

    risc_region_match #(
        .AW       (AW),
        .NREG     (NREG),
        .IW       (IW),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_match (
        .addr_i (cpu_addr_i),
        .hit_o  (matchHit),
        .idx_o  (matchIdx)
    );

    assign reqValid = cpu_rd_i | cpu_wr_i;
    assign reqBad   = (cpu_rd_i & cpu_wr_i) | ~matchHit;

    // State register; reset drops any access in flight back to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: requests are only looked at in IDLE, so mid-access changes are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    state_d = reqBad ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (waitCnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access context: latched when a good request is accepted, then the wait counter runs down
    // and read data is captured from the selected slave on the last strobe cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slvAddr_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            regIdx_q  <= '0;
            waitCnt_q <= '0;
            isWrite_q <= 1'b0;
        end else begin
            if (state_q == IDLE && reqValid && !reqBad) begin
                slvAddr_q <= cpu_addr_i & ~REG_MASK[int'(matchIdx)*AW +: AW];
                wdata_q   <= cpu_wdata_i;
                regIdx_q  <= matchIdx;
                waitCnt_q <= regWait(WAIT_TAB, int'(matchIdx));
                isWrite_q <= cpu_wr_i;
            end else if (state_q == ACCESS) begin
                if (waitCnt_q != '0) begin
                    waitCnt_q <= waitCnt_q - WAIT_W'(1);
                end else if (!isWrite_q) begin
                    rdata_q <= slv_rdata_i[int'(regIdx_q)*DW +: DW];
                end
            end
        end
    end

    // Output decode: strobes only in ACCESS, ready/err pulses come straight from RESP/ERR.
    always_comb begin
        slv_sel_o   = '0;
        slv_rd_o    = 1'b0;
        slv_wr_o    = 1'b0;
        cpu_ready_o = 1'b0;
        cpu_err_o   = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                slv_sel_o[regIdx_q] = 1'b1;
                slv_rd_o            = ~isWrite_q;
                slv_wr_o            = isWrite_q;
            end
            RESP: begin
                cpu_ready_o = 1'b1;
            end
            ERR: begin
                cpu_ready_o = 1'b1;
                cpu_err_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign slv_addr_o  = slvAddr_q;
    assign slv_wdata_o = wdata_q;
    assign cpu_rdata_o = rdata_q;

    // Bus protocol invariants: at most one slave selected, never read and write together,
    // and ready is always a single-cycle pulse.
    a_selOneHot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(slv_sel_o));
    a_rdWrExcl:  assert property (@(posedge clk_i) disable iff (rst_i) !(slv_rd_o && slv_wr_o));
    a_readyPulse: assert property (@(posedge clk_i) disable iff (rst_i)
                                   cpu_ready_o |=> !cpu_ready_o);

endmodule

// File: tb/tb_risc_mem_bus_ctrl.sv
// Self-checking bench for risc_mem_bus_ctrl. Two instances share the core-side
// stimulus: dutA uses the default ROM/RAM map, dutB a three-region map with an
// unmapped hole and a 15-wait region. A small behavioural model predicts
// region, wait states, offset, latency and read data for every request.
module tb_risc_mem_bus_ctrl;

    localparam int AW = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic cpuRd;
    logic cpuWr;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata;
    logic [2*DW-1:0] slvRdataA;
    logic [3*DW-1:0] slvRdataB;

    logic [DW-1:0] rdataA, slvWdataA;
    logic readyA, errA, busyA, slvRdA, slvWrA;
    logic [1:0] selA;
    logic [AW-1:0] slvAddrA;

    logic [DW-1:0] rdataB, slvWdataB;
    logic readyB, errB, busyB, slvRdB, slvWrB;
    logic [2:0] selB;
    logic [AW-1:0] slvAddrB;

    bit alt = 1'b0;
    int checks = 0;
    int passes = 0;
    time lastReady = 0;
    logic [DW-1:0] modelRdata [2];

    // Region maps as the core sees them: base, mask and wait states per region.
    logic [AW-1:0] baseTab [2][3] = '{'{13'h1800, 13'h0000, 13'h0000},
                                      '{13'h1000, 13'h0800, 13'h0400}};
    logic [AW-1:0] maskTab [2][3] = '{'{13'h1800, 13'h0000, 13'h0000},
                                      '{13'h1000, 13'h1800, 13'h1C00}};
    int waitTab [2][3] = '{'{0, 1, 0}, '{0, 15, 3}};
    int nregTab [2] = '{2, 3};

    logic obsReady, obsErr, obsBusy, obsRd, obsWr;
    logic [2:0] obsSel;
    logic [AW-1:0] obsAddr;
    logic [DW-1:0] obsWdata, obsRdata;

    assign obsReady = alt ? readyB : readyA;
    assign obsErr   = alt ? errB : errA;
    assign obsBusy  = alt ? busyB : busyA;
    assign obsRd    = alt ? slvRdB : slvRdA;
    assign obsWr    = alt ? slvWrB : slvWrA;
    assign obsSel   = alt ? selB : {1'b0, selA};
    assign obsAddr  = alt ? slvAddrB : slvAddrA;
    assign obsWdata = alt ? slvWdataB : slvWdataA;
    assign obsRdata = alt ? rdataB : rdataA;

    risc_mem_bus_ctrl dutA (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_rd_i    (cpuRd),
        .cpu_wr_i    (cpuWr),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_rdata_o (rdataA),
        .cpu_ready_o (readyA),
        .cpu_err_o   (errA),
        .busy_o      (busyA),
        .slv_sel_o   (selA),
        .slv_rd_o    (slvRdA),
        .slv_wr_o    (slvWrA),
        .slv_addr_o  (slvAddrA),
        .slv_wdata_o (slvWdataA),
        .slv_rdata_i (slvRdataA)
    );

    risc_mem_bus_ctrl #(
        .NREG     (3),
        .REG_BASE ({13'h0400, 13'h0800, 13'h1000}),
        .REG_MASK ({13'h1C00, 13'h1800, 13'h1000}),
        .REG_WAIT ({4'd3, 4'd15, 4'd0})
    ) dutB (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_rd_i    (cpuRd),
        .cpu_wr_i    (cpuWr),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_rdata_o (rdataB),
        .cpu_ready_o (readyB),
        .cpu_err_o   (errB),
        .busy_o      (busyB),
        .slv_sel_o   (selB),
        .slv_rd_o    (slvRdB),
        .slv_wr_o    (slvWrB),
        .slv_addr_o  (slvAddrB),
        .slv_wdata_o (slvWdataB),
        .slv_rdata_i (slvRdataB)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case the bench itself wedges.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time exhausted, expected summary before %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            passes++;
        end
    endtask

    // Region lookup from the map tables: first region whose masked address equals its base.
    function automatic int findRegion(input bit a, input logic [AW-1:0] addr);
        for (int r = 0; r < nregTab[a]; r++) begin
            if ((addr & maskTab[a][r]) == baseTab[a][r]) return r;
        end
        return -1;
    endfunction

    // Issue one core request and follow it to its ready pulse, checking strobes,
    // offset, latency and the returned data. A chained request is presented in the
    // ready cycle of the previous one and must start one IDLE cycle later.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [3*DW-1:0] dataVec,
                                 input bit chained, input bit scramble);
        int r;
        int waits;
        int readyAt;
        int strobes;
        logic expErr;
        logic errSeen;
        logic [AW-1:0] offset;
        logic [DW-1:0] expRdata;
        logic [2:0] expSel;
        bit selBad, addrBad, dirBad, dataBad;

        if (!chained) @(negedge clk);
        cpuRd     = rd;
        cpuWr     = wr;
        cpuAddr   = addr;
        cpuWdata  = wdata;
        slvRdataA = dataVec[2*DW-1:0];
        slvRdataB = dataVec;

        r        = findRegion(alt, addr);
        expErr   = (rd && wr) || (r < 0);
        waits    = 0;
        offset   = '0;
        expSel   = 3'b000;
        expRdata = modelRdata[alt];
        if (!expErr) begin
            waits  = waitTab[alt][r];
            offset = addr & ~maskTab[alt][r];
            expSel = 3'(1 << r);
            if (rd) expRdata = dataVec[r*DW +: DW];
        end

        repeat (chained ? 2 : 1) @(posedge clk);
        readyAt = 0;
        strobes = 0;
        errSeen = 1'b0;
        selBad  = 0;
        addrBad = 0;
        dirBad  = 0;
        dataBad = 0;
        for (int k = 1; k <= 40 && readyAt == 0; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput("busy in access", 32'(obsBusy), 32'd1);
            if (obsRd || obsWr) begin
                strobes++;
                if (obsSel !== expSel) selBad = 1;
                if (obsAddr !== offset) addrBad = 1;
                if (obsRd !== rd || obsWr !== wr) dirBad = 1;
                if (wr && obsWdata !== wdata) dataBad = 1;
            end
            if (obsReady) begin
                readyAt   = k;
                errSeen   = obsErr;
                lastReady = $time;
            end else if (scramble) begin
                cpuAddr  = AW'($urandom);
                cpuWdata = DW'($urandom);
            end
        end

        checkOutput("ready latency", 32'(readyAt), expErr ? 32'd1 : 32'(waits + 2));
        checkOutput("strobe cycles", 32'(strobes), expErr ? 32'd0 : 32'(waits + 1));
        checkOutput("err flag", 32'(errSeen), 32'(expErr));
        checkOutput("cpu rdata", 32'(obsRdata), 32'(expRdata));
        if (!expErr) begin
            checkOutput("slave select", 32'(selBad), 32'd0);
            checkOutput("slave offset", 32'(addrBad), 32'd0);
            checkOutput("strobe direction", 32'(dirBad), 32'd0);
            checkOutput("slave wdata", 32'(dataBad), 32'd0);
        end
        modelRdata[alt] = expRdata;
        cpuRd = 1'b0;
        cpuWr = 1'b0;
    endtask

    // Synchronous reset of both instances; the model forgets its last read value too.
    task automatic resetAll();
        @(negedge clk);
        rst   = 1'b1;
        cpuRd = 1'b0;
        cpuWr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelRdata[0] = '0;
        modelRdata[1] = '0;
    endtask

    initial begin
        int readies;
        int kind;
        logic rdR, wrR;
        time t0;

        rst       = 1'b1;
        cpuRd     = 1'b0;
        cpuWr     = 1'b0;
        cpuAddr   = '0;
        cpuWdata  = '0;
        slvRdataA = '0;
        slvRdataB = '0;
        modelRdata[0] = '0;
        modelRdata[1] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ctrl A", 32'({rdataA, readyA, errA, busyA, selA, slvRdA, slvWrA}), 32'd0);
        checkOutput("reset data A", 32'({slvAddrA, slvWdataA}), 32'd0);
        checkOutput("reset ctrl B", 32'({rdataB, readyB, errB, busyB, selB, slvRdB, slvWrB}), 32'd0);
        checkOutput("reset data B", 32'({slvAddrB, slvWdataB}), 32'd0);
        rst = 1'b0;

        // Default map: RAM read, ROM read, RAM write.
        alt = 1'b0;
        applyStimulus(1'b1, 1'b0, 13'h1805, 8'h00, 24'h0000A5, 1'b0, 1'b0);
        checkOutput("t1 ram rdata", 32'(rdataA), 32'h0000_00A5);
        applyStimulus(1'b1, 1'b0, 13'h0123, 8'h00, 24'h003C00, 1'b0, 1'b0);
        checkOutput("t2 rom rdata", 32'(rdataA), 32'h0000_003C);
        applyStimulus(1'b0, 1'b1, 13'h1FFF, 8'h5A, 24'h00FFFF, 1'b0, 1'b0);
        checkOutput("t3 rdata held", 32'(rdataA), 32'h0000_003C);

        // Back-to-back: ROM read with the RAM write presented in its ready cycle.
        applyStimulus(1'b1, 1'b0, 13'h0200, 8'h00, 24'h00C711, 1'b0, 1'b0);
        t0 = lastReady;
        applyStimulus(1'b0, 1'b1, 13'h1842, 8'h99, 24'h000000, 1'b1, 1'b0);
        checkOutput("t6 ready spacing", 32'(lastReady - t0), 32'd30);

        // Random traffic on the default map, with request inputs wiggled mid-access.
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 8);
            rdR  = (kind < 4) || (kind == 8);
            wrR  = (kind >= 4);
            applyStimulus(rdR, wrR, AW'($urandom), DW'($urandom), 24'($urandom),
                          1'($urandom_range(0, 1)), 1'b1);
        end

        // Sparse map with an unmapped hole.
        resetAll();
        alt = 1'b1;
        applyStimulus(1'b1, 1'b0, 13'h0010, 8'h00, 24'h123456, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 13'h1805, 8'h77, 24'h123456, 1'b0, 1'b0);
        checkOutput("t4 rdata after errors", 32'(rdataB), 32'd0);

        // Reset during the third strobe cycle of a 15-wait read.
        @(negedge clk);
        cpuRd     = 1'b1;
        cpuAddr   = 13'h0900;
        slvRdataB = 24'h00EE00;
        @(posedge clk);
        repeat (3) @(negedge clk);
        checkOutput("t5 strobe before reset", 32'({selB, slvRdB}), 32'b0101);
        rst   = 1'b1;
        cpuRd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5 idle after reset", 32'({selB, slvRdB, slvWrB, busyB, readyB}), 32'd0);
        rst = 1'b0;
        modelRdata[0] = '0;
        modelRdata[1] = '0;
        readies = 0;
        repeat (20) begin
            @(negedge clk);
            if (readyB) readies++;
        end
        checkOutput("t5 no ready after abort", 32'(readies), 32'd0);
        applyStimulus(1'b1, 1'b0, 13'h0900, 8'h00, 24'h00EE00, 1'b0, 1'b0);

        // Random traffic on the sparse map.
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 8);
            rdR  = (kind < 4) || (kind == 8);
            wrR  = (kind >= 4);
            applyStimulus(rdR, wrR, AW'($urandom), DW'($urandom), 24'($urandom),
                          1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
